rt_mode: RTL and testbench
==========================

# rt_mode

Rotation-mode CORDIC engine; the consumer of the direction bits produced by the vectoring-mode engine. It loads a 2-D vector, then applies ITER_NUM shift-add micro-rotations, one per received direction bit. It then scales both coordinates by the CORDIC gain constant and presents the rotated vector. In the Givens-rotation datapath it rotates the remaining matrix columns by the angle the vectoring engine measured.

## Interface

Parameters:
- INOUT_WIDTH, 16: width of signed two's-complement input/output coordinates.
- ITER_NUM, 9: number of micro-rotations (direction bits) per vector.

Ports:
- i_clk, input, 1: clock; all state updates on rising edge.
- i_rst_n, input, 1: reset; one clock, reset asynchronous and active-low.
- i_data_valid, input, 1: load strobe for i_data_x/i_data_y; honoured only in IDLE.
- i_data_x, input, INOUT_WIDTH: signed x coordinate.
- i_data_y, input, INOUT_WIDTH: signed y coordinate.
- i_d_valid, input, 1: direction bit present on i_d; honoured only in ROT.
- i_d, input, 1: rotation direction, with the same encoding as the vectoring engine's output.
- o_busy, output, 1: high whenever state != IDLE.
- o_valid, output, 1: one-cycle pulse; o_x/o_y hold the result.
- o_x, output, INOUT_WIDTH: scaled rotated x; holds its value until the next result.
- o_y, output, INOUT_WIDTH: scaled rotated y; holds its value until the next result.

## Operation

- Internal working registers x_r and y_r are INOUT_WIDTH+1 bits signed. An iteration counter it_r is 4 bits.
- FSM has three states: IDLE, ROT and SCALE.
- IDLE:
  - On i_data_valid, load x_r and y_r with sign-extended inputs and clear it_r.
  - Go to ROT.
- ROT, on a cycle with i_d_valid, perform one micro-rotation with shift s = it_r. Shifts are arithmetic (floor). Negation is taken before the shift.
  - i_d=0: x' = x + (y>>>s); y' = y + ((-x)>>>s).
  - i_d=1: x' = x + ((-y)>>>s); y' = y + (x>>>s).
- Micro-rotation width rule:
  - Sums are formed at INOUT_WIDTH+2 bits.
  - The stored result is {sum[MSB], sum[INOUT_WIDTH-1:0]}, i.e. bit INOUT_WIDTH is dropped with no saturation.
- ROT counting:
  - After each accepted bit, it_r increments.
  - The cycle that accepts the ITER_NUM-th bit moves the FSM to SCALE.
- ROT stalls: a cycle without i_d_valid holds all state, so gaps between direction bits are legal.
- SCALE, one cycle:
  - Multiply x_r and y_r each by K = 7'sb0100111 (39/64), giving a 24-bit signed product p.
  - Register o_x = o_y-style reduction {p[23], p[20:18], p[17:6]} for each coordinate.
  - Assert o_valid next cycle and return to IDLE.
- Ignored inputs:
  - i_data_valid outside IDLE.
  - i_d_valid outside ROT.
  - i_d_valid in the load cycle; the first bit is accepted no earlier than the cycle after the load.

## Timing

- Reset (i_rst_n=0, asynchronous):
  - state=IDLE, it_r=0.
  - o_valid=0, o_busy=0, o_x=0, o_y=0.
- Release is synchronous to the next edge.
- Nominal latency with a back-to-back bit stream:
  - Load edge at cycle 0.
  - Bits accepted at cycles 1..9.
  - SCALE at cycle 10.
  - o_valid high during cycle 11, exactly one cycle.
- With k idle cycles in the bit stream, o_valid moves k cycles later.
- o_busy rises the cycle after load and falls when o_valid rises.
- A new i_data_valid is accepted during the o_valid cycle, giving a 11-cycle initiation interval.
- Alignment rule: driving i_data_valid in the same cycle as the vectoring engine's i_data_valid aligns that engine's o_d/o_d_valid stream with i_d/i_d_valid directly.
- Reset asserted mid-ROT or SCALE:
  - Aborts immediately with no o_valid pulse.
  - Outputs cleared.
  - The next vector must be reloaded.

## Test plan

- Zero vector: load x=0, y=0; any 9 bits back-to-back -> o_valid at cycle 11; o_x=0, o_y=0.
- Nominal: load x=16384, y=0; i_d=1 for 9 consecutive cycles.
  - Pre-scale x=-4529, y=26596.
  - Required result: o_x=-2760 (0xF538), o_y=16206 (0x3F4E).
- Stall: repeat the nominal case with i_d_valid low for 3 cycles after the 4th bit -> identical result; o_valid at cycle 14; o_busy high throughout.
- Ignored strobes: during ROT, pulse i_data_valid with x=y=0x7FFF; assert i_d_valid in IDLE and in the load cycle -> result unchanged from the nominal case.
- Reset mid-operation: drop i_rst_n after the 5th bit -> o_busy, o_valid, o_x and o_y are 0 asynchronously; after release a fresh nominal run gives the nominal result.
- Random: 1000 random (x, y, 9-bit d) vectors, including ±32767 and -32768, back-to-back at an 11-cycle interval -> bit-exact match to the fixed-point model above (with wrap on bit INOUT_WIDTH).

Source files
------------

// File: rtl/rt_mode.sv
// rt_mode -- rotation-mode CORDIC engine.
//
// Loads a 2-D vector, applies ITER_NUM shift-add micro-rotations (one per
// accepted direction bit), scales both coordinates by the CORDIC gain
// K = 39/64 and presents the rotated vector for one o_valid cycle.
//
// Handshake: i_data_valid is a load strobe honoured only in IDLE. i_d_valid
// marks i_d as a direction bit and is honoured only in ROT; a ROT cycle
// without it holds all state. o_valid is a single-cycle pulse; o_x/o_y hold
// their value until the next result. Nothing here applies back-pressure.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_data_valid           load strobe for i_data_x / i_data_y
//   i_data_x, i_data_y     signed input coordinates
//   i_d_valid, i_d         direction bit stream (d=1: positive rotation)
//   o_busy                 high whenever the FSM is not IDLE
//   o_valid                one-cycle result strobe
//   o_x, o_y               scaled rotated coordinates
module rt_mode #(
  parameter int INOUT_WIDTH = 16,
  parameter int ITER_NUM    = 9
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_data_valid,
  input  logic signed [INOUT_WIDTH-1:0] i_data_x,
  input  logic signed [INOUT_WIDTH-1:0] i_data_y,
  input  logic                          i_d_valid,
  input  logic                          i_d,
  output logic                          o_busy,
  output logic                          o_valid,
  output logic signed [INOUT_WIDTH-1:0] o_x,
  output logic signed [INOUT_WIDTH-1:0] o_y
);

  localparam int XW = INOUT_WIDTH + 1;  // working register width
  localparam int SW = INOUT_WIDTH + 2;  // micro-rotation sum width
  localparam int PW = INOUT_WIDTH + 8;  // gain product width

  localparam logic signed [6:0] K_GAIN = 7'sb0100111;  // 39/64

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROT   = 2'd1,
    SCALE = 2'd2
  } state_t;

  state_t                 r_state;
  logic signed [XW-1:0]   r_x;
  logic signed [XW-1:0]   r_y;
  logic [3:0]             r_it;
  logic                   r_valid;
  logic signed [INOUT_WIDTH-1:0] r_ox;
  logic signed [INOUT_WIDTH-1:0] r_oy;

  logic signed [SW-1:0] w_xe, w_ye;
  logic signed [SW-1:0] w_x_sh, w_y_sh, w_nx_sh, w_ny_sh;
  logic signed [SW-1:0] w_x_sum, w_y_sum;
  logic signed [PW-1:0] w_px, w_py;
  logic                 w_last_bit;

  // Widen to the sum width first so that negating the most negative working
  // value cannot overflow; negation happens before the arithmetic shift.
  assign w_xe    = {r_x[XW-1], r_x};
  assign w_ye    = {r_y[XW-1], r_y};
  assign w_x_sh  = w_xe >>> r_it;
  assign w_y_sh  = w_ye >>> r_it;
  assign w_nx_sh = (-w_xe) >>> r_it;
  assign w_ny_sh = (-w_ye) >>> r_it;

  assign w_x_sum = w_xe + (i_d ? w_ny_sh : w_y_sh);
  assign w_y_sum = w_ye + (i_d ? w_x_sh  : w_nx_sh);

  // Operands sign-extended to the product width; the low PW bits of the
  // product are then exact for signed operands.
  assign w_px = {{(PW-XW){r_x[XW-1]}}, r_x} * {{(PW-7){K_GAIN[6]}}, K_GAIN};
  assign w_py = {{(PW-XW){r_y[XW-1]}}, r_y} * {{(PW-7){K_GAIN[6]}}, K_GAIN};

  assign w_last_bit = (r_it == 4'(ITER_NUM - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_it    <= '0;
      r_valid <= 1'b0;
      r_ox    <= '0;
      r_oy    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_data_valid) begin
            r_x     <= {i_data_x[INOUT_WIDTH-1], i_data_x};
            r_y     <= {i_data_y[INOUT_WIDTH-1], i_data_y};
            r_it    <= '0;
            r_state <= ROT;
          end
        end
        ROT: begin
          if (i_d_valid) begin
            // Drop bit INOUT_WIDTH of the sum: keep its sign plus the low bits.
            r_x  <= {w_x_sum[SW-1], w_x_sum[INOUT_WIDTH-1:0]};
            r_y  <= {w_y_sum[SW-1], w_y_sum[INOUT_WIDTH-1:0]};
            r_it <= r_it + 4'd1;
            if (w_last_bit) r_state <= SCALE;
          end
        end
        SCALE: begin
          // Divide by 64 and wrap into the output width, keeping the sign.
          r_ox    <= {w_px[PW-1], w_px[PW-4:6]};
          r_oy    <= {w_py[PW-1], w_py[PW-4:6]};
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy  = (r_state != IDLE);
  assign o_valid = r_valid;
  assign o_x     = r_ox;
  assign o_y     = r_oy;

endmodule

// File: tb/tb_rt_mode.sv
// Testbench for rt_mode: fixed vectors from a table, hand-written stall,
// ignored-strobe and mid-operation reset sequences, then randomized vectors
// compared against an arithmetic reference model.
module tb_rt_mode;

  logic               i_clk;
  logic               i_rst_n;
  logic               i_data_valid;
  logic signed [15:0] i_data_x;
  logic signed [15:0] i_data_y;
  logic               i_d_valid;
  logic               i_d;
  logic               o_busy;
  logic               o_valid;
  logic signed [15:0] o_x;
  logic signed [15:0] o_y;

  int n_checks = 0;
  int n_fail   = 0;

  rt_mode #(.INOUT_WIDTH(16), .ITER_NUM(9)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data_valid (i_data_valid),
    .i_data_x     (i_data_x),
    .i_data_y     (i_data_y),
    .i_d_valid    (i_d_valid),
    .i_d          (i_d),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_x          (o_x),
    .o_y          (o_y)
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Working value after a micro-rotation: the sum keeps its true sign but
  // only its low 16 magnitude bits (bit 16 of the sum is lost).
  function automatic int wrap_work(input int s);
    int lo;
    lo = s & 32'h0000FFFF;
    return (s < 0) ? lo - 65536 : lo;
  endfunction

  // Output: floor(p/64) reduced to 15 low bits, keeping the sign of p.
  function automatic int wrap_out(input int p);
    int q, lo;
    q  = p >>> 6;
    lo = q & 32'h00007FFF;
    return (p < 0) ? lo - 32768 : lo;
  endfunction

  function automatic void model(input int x0, input int y0, input logic [8:0] d,
                                output int ox, output int oy);
    int x, y, nx, ny;
    x = x0;
    y = y0;
    for (int i = 0; i < 9; i++) begin
      if (d[i]) begin
        nx = x + ((-y) >>> i);
        ny = y + (x >>> i);
      end else begin
        nx = x + (y >>> i);
        ny = y + ((-x) >>> i);
      end
      x = wrap_work(nx);
      y = wrap_work(ny);
    end
    ox = wrap_out(x * 39);
    oy = wrap_out(y * 39);
  endfunction

  // ---------------- driver ----------------
  // Entered and left #1 after a rising edge. Leaves off in the o_valid cycle
  // so the next call loads back-to-back (11-cycle interval).
  task automatic do_vec(input logic signed [15:0] x, input logic signed [15:0] y,
                        input logic [8:0] d, input int stall_at, input int stall_len,
                        input bit noise, input int ex, input int ey);
    int  cyc;
    bit  got;
    i_data_valid = 1'b1;
    i_data_x     = x;
    i_data_y     = y;
    if (noise) begin
      i_d_valid = 1'b1;  // must be ignored in the load cycle
      i_d       = ~d[0];
    end
    @(posedge i_clk); #1;
    i_data_valid = 1'b0;
    i_d_valid    = 1'b0;
    check("load_busy", int'(o_busy), 1);
    check("prev_valid_one_cycle", int'(o_valid), 0);
    cyc = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          @(posedge i_clk); #1;
          cyc++;
          check("stall_busy", int'(o_busy), 1);
        end
      end
      i_d_valid = 1'b1;
      i_d       = d[i];
      if (noise && i == 3) begin
        i_data_valid = 1'b1;  // must be ignored in ROT
        i_data_x     = 16'sh7FFF;
        i_data_y     = 16'sh7FFF;
      end
      @(posedge i_clk); #1;
      cyc++;
      i_d_valid    = 1'b0;
      i_data_valid = 1'b0;
    end
    check("after_last_bit_busy", int'(o_busy), 1);
    check("after_last_bit_valid", int'(o_valid), 0);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(posedge i_clk); #1;
      cyc++;
      if (o_valid) got = 1'b1;
    end
    check("valid_seen", int'(got), 1);
    check("valid_latency", cyc, 10 + stall_len);
    check("busy_low_with_valid", int'(o_busy), 0);
    check("o_x", int'(o_x), ex);
    check("o_y", int'(o_y), ey);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [8:0]         d;
    int                 ex;
    int                 ey;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int               rx, ry;
    logic signed [15:0] xv, yv;
    logic [8:0]       dv;

    tbl[0] = '{x: 16'sd0,     y: 16'sd0,     d: 9'h155, ex: 0,     ey: 0};
    tbl[1] = '{x: 16'sd16384, y: 16'sd0,     d: 9'h1FF, ex: -2760, ey: 16206};
    // Swapping x/y with d=0 mirrors the nominal recurrence.
    tbl[2] = '{x: 16'sd0,     y: 16'sd16384, d: 9'h000, ex: 16206, ey: -2760};
    tbl[3] = '{x: 16'sd0,     y: 16'sd0,     d: 9'h000, ex: 0,     ey: 0};

    i_rst_n      = 1'b0;
    i_data_valid = 1'b0;
    i_data_x     = '0;
    i_data_y     = '0;
    i_d_valid    = 1'b0;
    i_d          = 1'b0;

    #12;
    check("rst_busy", int'(o_busy), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_x", int'(o_x), 0);
    check("rst_y", int'(o_y), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Table vectors, back-to-back.
    for (int t = 0; t < 4; t++)
      do_vec(tbl[t].x, tbl[t].y, tbl[t].d, -1, 0, 1'b0, tbl[t].ex, tbl[t].ey);

    // Stall: 3 idle cycles after the 4th bit.
    do_vec(16'sd16384, 16'sd0, 9'h1FF, 4, 3, 1'b0, -2760, 16206);

    // Ignored strobes: d_valid in IDLE, in the load cycle, data_valid in ROT.
    i_d_valid = 1'b1;
    i_d       = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_d_valid = 1'b0;
    check("idle_dvalid_busy", int'(o_busy), 0);
    do_vec(16'sd16384, 16'sd0, 9'h1FF, -1, 0, 1'b1, -2760, 16206);

    // Reset after the 5th bit.
    i_data_valid = 1'b1;
    i_data_x     = 16'sd16384;
    i_data_y     = 16'sd0;
    @(posedge i_clk); #1;
    i_data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_d_valid = 1'b1;
      i_d       = 1'b1;
      @(posedge i_clk); #1;
      i_d_valid = 1'b0;
    end
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_x", int'(o_x), 0);
    check("midrst_y", int'(o_y), 0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("postrst_busy", int'(o_busy), 0);
    do_vec(16'sd16384, 16'sd0, 9'h1FF, -1, 0, 1'b0, -2760, 16206);

    // Randomized vectors against the model, back-to-back.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 7))
        0:       xv = 16'sd32767;
        1:       xv = -16'sd32768;
        2:       xv = -16'sd32767;
        default: xv = 16'($urandom_range(0, 65535));
      endcase
      case ($urandom_range(0, 7))
        0:       yv = 16'sd32767;
        1:       yv = -16'sd32768;
        2:       yv = -16'sd32767;
        default: yv = 16'($urandom_range(0, 65535));
      endcase
      dv = 9'($urandom_range(0, 511));
      model(int'(xv), int'(yv), dv, rx, ry);
      do_vec(xv, yv, dv, -1, 0, 1'b0, rx, ry);
    end

    @(posedge i_clk); #1;
    check("final_valid_low", int'(o_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
